// File: rtl/alu_exec_pipe.sv
// Two-stage ALU execution pipeline with valid/ready on both sides.
// S1 holds the accepted operation, S2 holds the computed result and drives out_*.
module alu_exec_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_ctrl,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_illegal
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  function automatic logic ctrl_is_illegal(input logic [3:0] ctrl);
    logic ill;
    case (ctrl)
      CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT, CTRL_NOR: ill = 1'b0;
      default:                                                   ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic [XLEN-1:0] alu_compute(input logic [3:0] ctrl,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    case (ctrl)
      CTRL_AND: res = a & b;
      CTRL_OR:  res = a | b;
      CTRL_ADD: res = a + b;
      CTRL_SUB: res = a - b;
      CTRL_SLT: res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      CTRL_NOR: res = ~(a | b);
      default:  res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  logic            s1_valid_r;
  logic [3:0]      s1_ctrl_r;
  logic [XLEN-1:0] s1_a_r;
  logic [XLEN-1:0] s1_b_r;
  logic            s1_illegal_r;

  logic            s2_valid_r;
  logic [XLEN-1:0] s2_result_r;
  logic            s2_zero_r;
  logic            s2_illegal_r;

  logic            s2_free_s;
  logic            s1_adv_s;
  logic            in_xfer_s;
  logic [XLEN-1:0] s1_result_s;

  // Handshake and advance decisions; in_ready looks through to out_ready by one level only.
  always_comb begin
    s2_free_s   = !s2_valid_r || out_ready;
    s1_adv_s    = s1_valid_r && s2_free_s;
    in_ready    = !s1_valid_r || s2_free_s;
    in_xfer_s   = in_valid && in_ready;
    if (s1_illegal_r) begin
      s1_result_s = {XLEN{1'b0}};
    end else begin
      s1_result_s = alu_compute(s1_ctrl_r, s1_a_r, s1_b_r);
    end
  end

  // Stage 1: capture the operation and its legality on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r   <= 1'b0;
      s1_ctrl_r    <= 4'b0000;
      s1_a_r       <= {XLEN{1'b0}};
      s1_b_r       <= {XLEN{1'b0}};
      s1_illegal_r <= 1'b0;
    end else begin
      if (in_xfer_s) begin
        s1_valid_r   <= 1'b1;
        s1_ctrl_r    <= in_ctrl;
        s1_a_r       <= in_a;
        s1_b_r       <= in_b;
        s1_illegal_r <= ctrl_is_illegal(in_ctrl);
      end else if (s1_adv_s) begin
        s1_valid_r <= 1'b0;
      end
    end
  end

  // Stage 2: output register; holds while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r   <= 1'b0;
      s2_result_r  <= {XLEN{1'b0}};
      s2_zero_r    <= 1'b0;
      s2_illegal_r <= 1'b0;
    end else begin
      if (s1_adv_s) begin
        s2_valid_r   <= 1'b1;
        s2_result_r  <= s1_result_s;
        s2_zero_r    <= (s1_result_s == {XLEN{1'b0}});
        s2_illegal_r <= s1_illegal_r;
      end else if (out_ready) begin
        s2_valid_r <= 1'b0;
      end
    end
  end

  assign out_valid   = s2_valid_r;
  assign out_result  = s2_result_r;
  assign out_zero    = s2_zero_r;
  assign out_illegal = s2_illegal_r;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed self-checking bench for alu_exec_pipe; inputs driven and outputs sampled on the falling edge.
module tb_alu_exec_pipe;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_ctrl;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic            out_illegal;

  int n_checks;
  int n_fail;

  alu_exec_pipe #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ctrl     (in_ctrl),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_ill);
    @(negedge clk);
    in_valid = 1'b1; in_ctrl = ctrl; in_a = a; in_b = b;
    check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_valid_lat1"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_result"}, out_result, exp_res);
    check_eq({tag, "_zero"}, {31'd0, out_zero}, {31'd0, exp_zero});
    check_eq({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, exp_ill});
    @(negedge clk);
    check_eq({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = 4'b0000;
    in_a = 32'd0; in_b = 32'd0; out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_result", out_result, 32'd0);
    check_eq("rst_out_zero", {31'd0, out_zero}, 32'd0);
    check_eq("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_op("add", 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    run_op("sub", 4'b0110, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);
    run_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    run_op("slt_false", 4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    run_op("nor", 4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("ill", 4'b0011, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b1);
    run_op("and", 4'b0000, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b0, 1'b0);
    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0);

    // Back-to-back adds at full throughput.
    for (int cyc = 0; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc < 8) begin
        in_valid = 1'b1; in_ctrl = 4'b0010; in_a = cyc; in_b = 32'd1;
        check_eq($sformatf("b2b_in_ready_%0d", cyc), {31'd0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      if (cyc >= 2 && cyc < 10) begin
        check_eq($sformatf("b2b_valid_%0d", cyc), {31'd0, out_valid}, 32'd1);
        check_eq($sformatf("b2b_result_%0d", cyc), out_result, cyc - 1);
      end else begin
        check_eq($sformatf("b2b_idle_%0d", cyc), {31'd0, out_valid}, 32'd0);
      end
    end

    // Stall with out_ready low: two accepted, third held off.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 4'b0010; in_a = 32'd100; in_b = 32'd1;
    #1 check_eq("stall_rdy0", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_ctrl = 4'b0001; in_a = 32'h0F; in_b = 32'hF0;
    check_eq("stall_rdy1", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_ctrl = 4'b0110; in_a = 32'd50; in_b = 32'd8;
    check_eq("stall_rdy2", {31'd0, in_ready}, 32'd0);
    check_eq("stall_valid2", {31'd0, out_valid}, 32'd1);
    check_eq("stall_res2", out_result, 32'd101);
    @(negedge clk);
    check_eq("stall_rdy3", {31'd0, in_ready}, 32'd0);
    check_eq("stall_res3", out_result, 32'd101);
    @(negedge clk);
    check_eq("stall_res4", out_result, 32'd101);
    out_ready = 1'b1;
    #1 check_eq("stall_release_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("drain_valid_b", {31'd0, out_valid}, 32'd1);
    check_eq("drain_res_b", out_result, 32'h0000_00FF);
    @(negedge clk);
    check_eq("drain_valid_c", {31'd0, out_valid}, 32'd1);
    check_eq("drain_res_c", out_result, 32'd42);
    @(negedge clk);
    check_eq("drain_empty", {31'd0, out_valid}, 32'd0);

    // Fill the pipe, then reset while FULL.
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 4'b0010; in_a = 32'd7; in_b = 32'd7;
    @(negedge clk);
    in_a = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("full_rdy", {31'd0, in_ready}, 32'd0);
    check_eq("full_res", out_result, 32'd14);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("async_rst_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    check_eq("post_rst_valid0", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq("post_rst_valid1", {31'd0, out_valid}, 32'd0);
    check_eq("post_rst_result", out_result, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_pipe.md
Name: alu_exec_pipe

Overview:
- Execution-side consumer of the 4-bit ALU control code produced by the ALU control decoder.
- Accepts one operation per transfer: a code and two operands, over a valid/ready handshake.
- Computes the result in a 2-stage pipeline with full backpressure, and returns the result, a zero flag and an illegal-code flag over a second valid/ready handshake.
- Sits between the decode/operand-fetch stage and writeback in the multi-cycle datapath variant.

Parameters:
- XLEN, 32: operand and result width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept the operation this cycle
- in_ctrl  input  4  ALU control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- in_a  input  XLEN  operand A
- in_b  input  XLEN  operand B
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- out_result  output  XLEN  computed result
- out_zero  output  1  out_result == 0
- out_illegal  output  1  in_ctrl was not one of the six defined codes

Behaviour:
- Reset (async assert on rst_n low, synchronous release):
  - All stage valid bits clear: out_valid=0.
  - out_result=0, out_zero=0, out_illegal=0.
  - in_ready=1 from the first cycle after rst_n goes high.
- Transfers:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready at a rising edge.
  - in_ctrl, in_a and in_b are sampled only on an input transfer.
- Stage 1 (S1) captures on input transfer: ctrl, a, b, and an illegal bit decoded from ctrl.
- Stage 2 (S2, output register) captures from S1:
  - result, zero = (result==0), illegal.
  - out_* are driven directly from S2 registers. No combinational path from in_* to out_*.
- Advance rules:
  - s2_free = !s2_valid || out_ready.
  - S1 -> S2 when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is combinational on out_ready; one level only.
- Latency and throughput:
  - Minimum latency is 2 cycles: transfer at edge N gives out_valid=1 after edge N+1.
  - Throughput is 1 op/cycle with out_ready held high.
- Backpressure: while out_ready=0 and both stages are valid, in_ready=0. S1 and S2 hold their contents unchanged and no data is lost or duplicated.
- Arithmetic:
  - ADD/SUB are modulo 2^XLEN. Carry and overflow are not reported.
  - SLT is a signed two's-complement compare; result = {XLEN-1 zeros, (a<b)}.
  - NOR = ~(a|b).
- Illegal code: result=0, out_zero=1, out_illegal=1. The op still flows through the pipeline and must be accepted downstream like any other.
- Simultaneous events: an input transfer in the same cycle S1 drains to S2 is allowed. S1 loads the new op while S2 loads the old one.
- Ordering: strict FIFO, in input order.
- Reset mid-operation: in-flight ops are discarded, with no output transfer for them.
- State summary:
  - EMPTY (s1=0, s2=0)
  - ONE (exactly one stage valid)
  - FULL (s1=1, s2=1)
  - FULL is left only by an output transfer.

Test Plan:
- Reset then single op, ctrl=0010, a=5, b=7, out_ready=1 -> out_valid rises 2 edges later with result=12, zero=0, illegal=0; out_valid drops the next cycle.
- ctrl=0110, a=3, b=3 -> result=0, zero=1. ctrl=0111, a=0xFFFFFFFF, b=1 -> result=1 (signed -1<1). ctrl=1100, a=0, b=0 -> 0xFFFFFFFF.
- ctrl=0011, any operands -> result=0, zero=1, illegal=1; the next legal op (0000, a=0xF0, b=0x3C, result=0x30) follows without disturbance.
- Back-to-back 8 ADDs (a=i, b=1) with out_ready=1 -> 8 consecutive out_valid cycles, results 1..8 in order, in_ready constantly 1.
- Stall: out_ready=0 while feeding 3 ops -> first two accepted, in_ready=0 on the third; out_result stable. Raising out_ready -> all 3 emerge in order with none dropped or duplicated.
- Pull rst_n low while FULL -> out_valid=0 and out_result=0 immediately (async). After release, in_ready=1 and no stale result appears.
